// File: rtl/multiplier.sv
// Sequential unsigned n x n shift-add multiplier on a shared bidirectional bus.
// Operands load by function code; the 2n-bit product is read back one half at a time.
module multiplier #(
  parameter int n = 8
) (
  input  logic         clock,
  input  logic         nReset,
  input  logic         start,
  input  logic [1:0]   func,
  input  logic         oe,
  output logic         ready,
  inout  wire  [n-1:0] data
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] BUSY = 1'b1;
  localparam int CW = $clog2(n) + 1;

  logic [0:0]     state;
  logic           start_q;
  logic           start_edge;
  logic [n-1:0]   a;
  logic [n-1:0]   b;
  logic [n-1:0]   mcand;
  logic [2*n-1:0] p;
  logic [CW-1:0]  count;
  logic [n:0]     sum;

  assign start_edge = start & ~start_q;

  // Upper half plus conditional addend, carry kept in the top bit for the shift-in.
  always_comb begin
    sum = {1'b0, p[2*n-1:n]} + (p[0] ? {1'b0, mcand} : '0);
  end

  always_ff @(posedge clock or negedge nReset) begin
    if (!nReset) begin
      state   <= IDLE;
      ready   <= 1'b1;
      start_q <= 1'b0;
      a       <= '0;
      b       <= '0;
      mcand   <= '0;
      p       <= '0;
      count   <= '0;
    end else begin
      start_q <= start;
      case (state)
        IDLE: begin
          if (start_edge) begin
            p     <= {{n{1'b0}}, b};
            mcand <= a;
            count <= '0;
            ready <= 1'b0;
            state <= BUSY;
          end else begin
            case (func)
              2'b00:   a <= data;
              2'b01:   b <= data;
              default: ;
            endcase
          end
        end
        default: begin
          p     <= {sum, p[n-1:1]};
          count <= count + 1'b1;
          if (count == CW'(n - 1)) begin
            state <= IDLE;
            ready <= 1'b1;
          end
        end
      endcase
    end
  end

  assign data = (oe && func == 2'b10) ? p[2*n-1:n] :
                (oe && func == 2'b11) ? p[n-1:0]   : 'z;

endmodule

// File: tb/tb_multiplier.sv
// Self-checking bench for multiplier: directed steps plus random operands,
// checked against an arithmetic product model.
module tb_multiplier;

  logic       clock;
  logic       nReset;
  logic       start;
  logic [1:0] func;
  logic       oe;
  logic       ready;
  wire  [7:0] data;
  logic [7:0] drv_val;
  logic       drv_en;

  int errors;
  int checks;

  logic [7:0]  exp_a;
  logic [7:0]  exp_b;
  logic [15:0] prod;

  assign data = drv_en ? drv_val : 'z;

  multiplier #(.n(8)) dut (
    .clock (clock),
    .nReset(nReset),
    .start (start),
    .func  (func),
    .oe    (oe),
    .ready (ready),
    .data  (data)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic load(input logic [1:0] f, input logic [7:0] v);
    @(negedge clock);
    func    = f;
    drv_val = v;
    drv_en  = 1'b1;
    @(negedge clock);
    drv_en  = 1'b0;
    func    = 2'b10;
    if (f == 2'b00) exp_a = v;
    else            exp_b = v;
  endtask

  task automatic read_chk(input string tag, input logic [1:0] f, input logic [7:0] exp);
    @(negedge clock);
    drv_en = 1'b0;
    func   = f;
    oe     = 1'b1;
    #1;
    check(tag, {8'h00, data}, {8'h00, exp});
    @(negedge clock);
    oe   = 1'b0;
    func = 2'b10;
  endtask

  task automatic read_prod(input string tag);
    prod = 16'(exp_a) * 16'(exp_b);
    read_chk({tag, "_hi"}, 2'b10, prod[15:8]);
    read_chk({tag, "_lo"}, 2'b11, prod[7:0]);
  endtask

  // Launch a multiply with start held for 'hold' edges; optionally try to disturb it while busy.
  task automatic run_mul(input string tag, input int hold, input bit lockout);
    int  rise;
    bit  dip;
    @(negedge clock);
    start = 1'b1;
    func  = 2'b11;
    rise  = -1;
    dip   = 1'b0;
    @(negedge clock);
    check({tag, "_busy"}, {15'd0, ready}, 16'd0);
    for (int i = 1; i <= 20; i++) begin
      if (i >= hold) start = 1'b0;
      if (lockout) begin
        if (i == 3) begin func = 2'b00; drv_val = 8'hFF; drv_en = 1'b1; end
        if (i == 4) begin drv_en = 1'b0; func = 2'b11; start = 1'b1; end
        if (i == 5) start = 1'b0;
      end
      @(negedge clock);
      if (ready && rise < 0) rise = i;
      if (!ready && rise >= 0) dip = 1'b1;
    end
    start = 1'b0;
    func  = 2'b10;
    check({tag, "_latency"}, 16'(rise), 16'd8);
    check({tag, "_norestart"}, {15'd0, dip}, 16'd0);
    read_prod(tag);
  endtask

  task automatic tri_chk(input string tag, input logic o, input logic [1:0] f);
    logic [7:0] v;
    v = 8'($urandom);
    @(negedge clock);
    oe      = o;
    func    = f;
    drv_val = v;
    drv_en  = 1'b1;
    #1;
    check(tag, {8'h00, data}, {8'h00, v});
    @(negedge clock);
    drv_en = 1'b0;
    oe     = 1'b0;
    func   = 2'b10;
    if (f == 2'b00) exp_a = v;
    if (f == 2'b01) exp_b = v;
  endtask

  initial begin
    errors  = 0;
    checks  = 0;
    nReset  = 1'b0;
    start   = 1'b0;
    func    = 2'b10;
    oe      = 1'b0;
    drv_en  = 1'b0;
    drv_val = '0;
    exp_a   = '0;
    exp_b   = '0;

    repeat (2) @(negedge clock);
    check("reset_ready", {15'd0, ready}, 16'd1);
    nReset = 1'b1;
    read_prod("reset_p");

    load(2'b00, 8'd123);
    load(2'b01, 8'd234);
    run_mul("basic", 1, 1'b0);

    load(2'b00, 8'h55);
    load(2'b01, 8'hAA);
    run_mul("held", 3, 1'b0);
    run_mul("held_long", 12, 1'b0);

    load(2'b00, 8'h37);
    load(2'b01, 8'hC9);
    run_mul("lockout", 1, 1'b0);
    run_mul("lockout", 1, 1'b1);
    run_mul("lockout_a_kept", 1, 1'b0);

    load(2'b00, 8'hFF);
    load(2'b01, 8'hFF);
    run_mul("ff_ff", 1, 1'b0);
    load(2'b00, 8'h00);
    load(2'b01, 8'hAB);
    run_mul("zero", 1, 1'b0);
    load(2'b00, 8'h01);
    load(2'b01, 8'h80);
    run_mul("one", 1, 1'b0);

    for (int t = 0; t < 6; t++) begin
      load(2'b00, 8'($urandom));
      load(2'b01, 8'($urandom));
      run_mul("rand", 1, 1'b0);
    end

    tri_chk("tri_oe0_f00", 1'b0, 2'b00);
    tri_chk("tri_oe0_f11", 1'b0, 2'b11);
    tri_chk("tri_oe1_f00", 1'b1, 2'b00);
    tri_chk("tri_oe1_f01", 1'b1, 2'b01);
    run_mul("tri_loaded", 1, 1'b0);

    // Reset during a multiply: must abort and clear everything.
    @(negedge clock);
    start = 1'b1;
    func  = 2'b11;
    @(negedge clock);
    start = 1'b0;
    repeat (3) @(negedge clock);
    nReset = 1'b0;
    #1;
    check("midreset_ready", {15'd0, ready}, 16'd1);
    @(negedge clock);
    nReset = 1'b1;
    func   = 2'b10;
    exp_a  = '0;
    exp_b  = '0;
    tri_chk("midreset_tri", 1'b0, 2'b10);
    read_prod("midreset_p");

    load(2'b00, 8'd200);
    load(2'b01, 8'd3);
    run_mul("after_reset", 1, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/multiplier.md
Name: multiplier

Overview:
- Sequential unsigned n×n shift-add multiplier with a shared n-bit bidirectional data bus.
- Operands are loaded over the bus by function code. A start pulse launches an n-cycle multiply, and the 2n-bit product is read back one half at a time under output enable.
- Used as a bus-attached arithmetic peripheral in a lab datapath.

Parameters:
- n, 8, operand width in bits. Product width is 2n. Any n ≥ 2 is legal.

Ports:
- clock  input  1  system clock; all state updates on the rising edge
- nReset  input  1  asynchronous active-low reset
- start  input  1  multiply request; rising edge detected internally
- func  input  2  function select: 00 load A, 01 load B, 10 select product high half, 11 select product low half / start code
- oe  input  1  output enable for reading the product onto data
- ready  output  1  high when idle (no multiply in progress)
- data  inout  n  shared bus; input for operand loads, tri-state output for product reads

Behaviour:
- Reset (nReset low, asynchronous):
  - A, B, P (2n-bit product) and the cycle counter clear to 0.
  - State goes to IDLE, ready=1, start-edge register cleared, data released to high-Z.
- States: IDLE, BUSY.
- Start detection:
  - A registered copy of start is kept.
  - startEdge = start & ~start_q.
  - A held-high start triggers exactly once.
  - start is accepted only in IDLE. Its rising edge is ignored in BUSY.
  - func value is ignored for start.
- Operand load, IDLE only, sampled at clock edge:
  - Loads occur only when startEdge=0.
  - func=00 loads A <= data.
  - func=01 loads B <= data.
  - func=10/11 leave A and B unchanged.
  - In BUSY all loads are ignored.
- IDLE → BUSY on startEdge:
  - Same edge: P <= {n'b0, B}, working multiplicand <= A, counter <= 0, ready <= 0.
- BUSY iteration, one per clock:
  - If P[0]=1, add multiplicand to P[2n-1:n] with carry out c; otherwise c=0.
  - Then P <= {c, upper+addend, P[n-1:1]} (shift right 1 with carry in).
  - counter increments.
  - After the n-th iteration, state returns to IDLE and ready <= 1.
- Latency:
  - startEdge sampled at edge k.
  - Iterations occur on edges k+1 … k+n.
  - ready is high and P holds the final product after edge k+n.
- Product is unsigned: P = A*B, full 2n bits, no overflow possible.
- P retains its value in IDLE until the next start. A and B retain their values across multiplies.
- Bus drive (combinational, any state):
  - oe=1 & func=10 drives data = P[2n-1:n].
  - oe=1 & func=11 drives data = P[n-1:0].
  - All other combinations drive high-Z.
  - Reading during BUSY returns the partial product; this is not an error.
- The bench must not drive data while oe=1 & func[1]=1. Such bus contention is outside this block's control.
- Reset asserted mid-multiply aborts immediately to reset values. A later start begins a fresh operation.
- Simultaneous load code and startEdge in IDLE: start wins and no load occurs.

Test Plan:
- Reset: assert nReset low mid-operation -> ready=1, data high-Z, P reads 0x0000 after release.
- Basic multiply, n=8:
  - Stimulus: load A=123 (func 00), B=234 (func 01), one-cycle start with func 11.
  - ready=0 for 8 cycles, then 1.
  - oe with func 10 reads 0x70; oe with func 11 reads 0x6E (28782).
- Held start:
  - Stimulus: load A=0x55, B=0xAA, hold start high 3 cycles.
  - Exactly one operation occurs; ready rises 8 cycles after the start edge.
  - Reads give 0x38 (func 10) and 0x72 (func 11).
- Busy lockout: during BUSY apply func 00 with data 0xFF and a second start edge -> A unchanged, result unaffected, no restart.
- Boundaries: 0xFF*0xFF -> 0xFE01; 0*0xAB -> 0x0000; 1*0x80 -> 0x0080.
- Tri-state: oe=0 with any func, or oe=1 with func 00/01 -> data high-Z; the bench drives data freely with no conflict.
